// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_core's transmitter.
// The CPU writes bursts; a 3-state launcher drains one byte per transfer.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clear_overflow,
  output logic              idle,
  output logic [7:0]        data_tx,
  output logic              have_data_tx,
  input  logic              transmitting
);

  typedef enum logic [1:0] {
    IDLE,
    SENT,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   cnt;
  state_t            state;
  logic              push;
  logic              pop;

  assign full  = (cnt == FULL_LVL);
  assign empty = (cnt == '0);
  assign level = cnt;
  assign idle  = empty && (state == IDLE) && !transmitting;

  // full is the pre-edge value, so a pop in the same cycle cannot make room
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty && !transmitting;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // a new drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      data_tx      <= 8'h00;
      have_data_tx <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            data_tx      <= mem[rd_ptr];
            have_data_tx <= 1'b1;
            rd_ptr       <= rd_ptr + 1'b1;
            state        <= SENT;
          end
        end
        SENT: begin
          have_data_tx <= 1'b0;
          state        <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!transmitting) begin
            state <= IDLE;
          end
        end
        default: begin
          have_data_tx <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo.
// A queue scoreboard and a simple core model check every cycle.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       full, empty, overflow, idle;
  logic [4:0] level;
  logic [7:0] data_tx;
  logic       have_data_tx;
  logic       transmitting;

  logic hold = 1'b0;
  logic busy = 1'b0;
  int   bcnt = 0;
  int   tx_len = 1;
  logic rand_len = 1'b0;

  int checks = 0;
  int errors = 0;
  int launches = 0;

  logic [7:0] q[$];
  logic       exp_ovf = 1'b0;
  logic       prev_have = 1'b0;
  logic       tr_q = 1'b0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow),
    .clear_overflow(clear_overflow),
    .idle(idle),
    .data_tx(data_tx),
    .have_data_tx(have_data_tx),
    .transmitting(transmitting)
  );

  always #5 clk = ~clk;

  // core model: busy starts the cycle after the launch pulse
  assign transmitting = busy | hold;

  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      bcnt <= 0;
    end else if (have_data_tx) begin
      busy <= 1'b1;
      bcnt <= rand_len ? int'($urandom_range(1, 6)) : tx_len;
    end else if (busy) begin
      if (bcnt <= 1) busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  // scoreboard: bytes leave in push order; a full FIFO drops the write
  always @(posedge clk) begin
    logic [7:0] exp;
    if (rst) begin
      q.delete();
      exp_ovf   = 1'b0;
      prev_have = 1'b0;
      tr_q      = 1'b0;
    end else begin
      if (have_data_tx) begin
        checks++;
        assert (prev_have === 1'b0) else begin
          errors++;
          $error("FAIL pulse_width obs=%b exp=0", prev_have);
        end
        checks++;
        assert (tr_q === 1'b0) else begin
          errors++;
          $error("FAIL launch_while_busy obs=%b exp=0", tr_q);
        end
        checks++;
        assert (q.size() > 0) else begin
          errors++;
          $error("FAIL spurious_launch obs=%0d exp=>0", q.size());
        end
        if (q.size() > 0) begin
          exp = q.pop_front();
          launches++;
          checks++;
          assert (data_tx === exp) else begin
            errors++;
            $error("FAIL data_tx obs=%h exp=%h", data_tx, exp);
          end
        end
      end
      checks++;
      assert (level === 5'(q.size())) else begin
        errors++;
        $error("FAIL level obs=%0d exp=%0d", level, q.size());
      end
      checks++;
      assert (full === (q.size() == DEPTH)) else begin
        errors++;
        $error("FAIL full obs=%b exp=%b", full, q.size() == DEPTH);
      end
      checks++;
      assert (empty === (q.size() == 0)) else begin
        errors++;
        $error("FAIL empty obs=%b exp=%b", empty, q.size() == 0);
      end
      checks++;
      assert (overflow === exp_ovf) else begin
        errors++;
        $error("FAIL overflow obs=%b exp=%b", overflow, exp_ovf);
      end
      if (clear_overflow) exp_ovf = 1'b0;
      if (wr_en) begin
        if (q.size() < DEPTH) q.push_back(wr_data);
        else exp_ovf = 1'b1;
      end
      prev_have = have_data_tx;
      tr_q      = transmitting;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(idle === 1'b1 && q.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int l0;
    int sent;
    int g;

    // 1: reset state and single-byte latency
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_have", 32'(have_data_tx), 32'd0);
    chk("rst_data", 32'(data_tx), 32'h00);
    wr_data = 8'h55;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("lat_n", 32'(have_data_tx), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_n1", 32'(have_data_tx), 32'd1);
    chk("lat_data", 32'(data_tx), 32'h55);
    @(posedge clk);
    #1;
    chk("lat_n2", 32'(have_data_tx), 32'd0);
    @(negedge clk);
    wait_drain();
    chk("t1_idle", 32'(idle), 32'd1);
    chk("t1_data_hold", 32'(data_tx), 32'h55);

    // 2: three back-to-back bytes
    l0 = launches;
    push(8'h55);
    push(8'hA5);
    push(8'h0F);
    wait_drain();
    chk("t2_launches", 32'(launches - l0), 32'd3);
    chk("t2_level", 32'(level), 32'd0);

    // 3: fill while core busy, overflow, clear, drain
    hold = 1'b1;
    l0 = launches;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    push(8'hEE);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_no_launch", 32'(launches - l0), 32'd0);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    chk("t3_clr", 32'(overflow), 32'd0);
    hold = 1'b0;
    wait_drain();
    chk("t3_launches", 32'(launches - l0), 32'd16);

    // 4: write at full in the same cycle as a pop
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    hold    = 1'b0;
    wr_data = 8'h77;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("t4_level", 32'(level), 32'd15);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_have", 32'(have_data_tx), 32'd1);
    @(negedge clk);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    wait_drain();

    // 5: random groups with interleaved drain, pointers wrap
    rand_len = 1'b1;
    l0 = launches;
    sent = 0;
    while (sent < 20) begin
      g = int'($urandom_range(1, 6));
      if (g > 20 - sent) g = 20 - sent;
      for (int i = 0; i < g; i++) push(8'($urandom));
      sent += g;
      tick(int'($urandom_range(0, 15)));
    end
    wait_drain();
    chk("t5_launches", 32'(launches - l0), 32'd20);
    rand_len = 1'b0;

    // 6: reset while waiting on the core
    tx_len = 12;
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    tick(1);
    chk("t6_pre_level", 32'(level), 32'd5);
    chk("t6_pre_busy", 32'(transmitting), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_have", 32'(have_data_tx), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    l0 = launches;
    tick(20);
    chk("t6_quiet", 32'(launches - l0), 32'd0);
    chk("t6_have2", 32'(have_data_tx), 32'd0);
    tx_len = 1;
    push(8'h3C);
    wait_drain();
    chk("t6_relaunch", 32'(launches - l0), 32'd1);
    chk("t6_data", 32'(data_tx), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
